// File: rtl/multiword_ls_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multiword_ls_sequencer
// Purpose  : Decode-stage sequencer that expands lmw/stmw into one lwz/stw
//            micro-op per register and passes all other instructions through.
// Revision : 1.0 - initial release
// ============================================================================
module multiword_ls_sequencer #(
  parameter int INSTR_WIDTH = 32,
  parameter int LMW_OPCD    = 46,
  parameter int STMW_OPCD   = 47,
  parameter int LWZ_OPCD    = 32,
  parameter int STW_OPCD    = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   out_ofs_ovf,
  output logic                   illegal
);

  localparam logic [5:0] c_LMW  = 6'(LMW_OPCD);
  localparam logic [5:0] c_STMW = 6'(STMW_OPCD);
  localparam logic [5:0] c_LWZ  = 6'(LWZ_OPCD);
  localparam logic [5:0] c_STW  = 6'(STW_OPCD);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEQ  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [4:0]        r_cnt;
  logic [5:0]        r_opc;
  logic [4:0]        r_rt;
  logic [4:0]        r_ra;
  logic signed [16:0] r_ofs;

  logic                   r_out_valid;
  logic [INSTR_WIDTH-1:0] r_out_instr;
  logic                   r_out_last;
  logic                   r_out_ovf;
  logic                   r_illegal;

  logic w_slot_free;
  logic w_in_ready;
  logic w_emit_seq;
  logic w_accept;

  // Big-endian fields: OPCD[0:5] RT[6:10] RA[11:15] D[16:31] (INSTR_WIDTH = 32)
  logic [5:0]  w_opcd;
  logic [4:0]  w_rt;
  logic [4:0]  w_ra;
  logic [15:0] w_d;
  logic        w_is_lmw;
  logic        w_is_mw;
  logic        w_bad_lmw;
  logic [4:0]  w_first_cnt;
  logic [5:0]  w_first_opc;

  logic [4:0]         w_next_rt;
  logic signed [16:0] w_next_ofs;
  logic               w_next_ovf;

  assign w_opcd      = in_instr[INSTR_WIDTH-1  -: 6];
  assign w_rt        = in_instr[INSTR_WIDTH-7  -: 5];
  assign w_ra        = in_instr[INSTR_WIDTH-12 -: 5];
  assign w_d         = in_instr[INSTR_WIDTH-17 -: 16];
  assign w_is_lmw    = (w_opcd == c_LMW);
  assign w_is_mw     = w_is_lmw || (w_opcd == c_STMW);
  assign w_bad_lmw   = w_is_lmw && (w_ra != 5'd0) && (w_rt <= w_ra);
  assign w_first_cnt = 5'd31 - w_rt;
  assign w_first_opc = w_is_lmw ? c_LWZ : c_STW;

  // r_ofs never truncates: max |D+4k| fits easily in 17 bits
  assign w_next_rt  = r_rt + 5'd1;
  assign w_next_ofs = r_ofs + 17'sd4;
  assign w_next_ovf = (w_next_ofs[16] != w_next_ofs[15]);

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = in_valid && w_in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept && w_is_mw && !w_bad_lmw && (w_first_cnt != 5'd0)) begin
          w_state_nxt = c_SEQ;
        end
      end
      c_SEQ: begin
        if (flush) begin
          w_state_nxt = c_IDLE;
        end else if (w_emit_seq && (r_cnt == 5'd1)) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_in_ready = 1'b0;
    w_emit_seq = 1'b0;
    case (r_state)
      c_IDLE:  w_in_ready = w_slot_free && !flush;
      c_SEQ:   w_emit_seq = w_slot_free && !flush;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Output slot and sequence datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_last  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_illegal   <= 1'b0;
      r_cnt       <= 5'd0;
      r_opc       <= 6'd0;
      r_rt        <= 5'd0;
      r_ra        <= 5'd0;
      r_ofs       <= 17'sd0;
    end else begin
      r_illegal <= w_accept && w_bad_lmw;
      if (flush) begin
        r_out_valid <= 1'b0;
        r_cnt       <= 5'd0;
      end else if (w_accept) begin
        if (!w_is_mw) begin
          r_out_valid <= 1'b1;
          r_out_instr <= in_instr;
          r_out_last  <= 1'b1;
          r_out_ovf   <= 1'b0;
        end else if (w_bad_lmw) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= 1'b1;
          r_out_instr <= {w_first_opc, w_rt, w_ra, w_d};
          r_out_last  <= (w_rt == 5'd31);
          r_out_ovf   <= 1'b0;
          r_cnt       <= w_first_cnt;
          r_opc       <= w_first_opc;
          r_rt        <= w_rt;
          r_ra        <= w_ra;
          r_ofs       <= {w_d[15], w_d};
        end
      end else if (w_emit_seq) begin
        r_out_valid <= 1'b1;
        r_out_instr <= {r_opc, w_next_rt, r_ra, w_next_ofs[15:0]};
        r_out_last  <= (r_cnt == 5'd1);
        r_out_ovf   <= w_next_ovf;
        r_cnt       <= r_cnt - 5'd1;
        r_rt        <= w_next_rt;
        r_ofs       <= w_next_ofs;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_last    = r_out_last;
  assign out_ofs_ovf = r_out_ovf;
  assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multiword_ls_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_ls_sequencer
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based micro-op model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiword_ls_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, out_ofs_ovf, illegal;
  logic [31:0] out_instr;

  int errors = 0;
  int checks = 0;
  int fired_dut = 0;
  int ovf_dut = 0;

  always #5 clk = ~clk;

  multiword_ls_sequencer #(
    .INSTR_WIDTH(32), .LMW_OPCD(46), .STMW_OPCD(47), .LWZ_OPCD(32), .STW_OPCD(36)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_ready(out_ready),
    .out_last(out_last), .out_ofs_ovf(out_ofs_ovf), .illegal(illegal)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        ovf;
  } uop_t;

  uop_t m_pending[$];
  uop_t m_slot;
  logic m_slot_valid = 1'b0;
  logic m_illegal = 1'b0;

  function automatic void model_reset();
    m_pending.delete();
    m_slot_valid = 1'b0;
    m_illegal = 1'b0;
  endfunction

  function automatic logic model_in_ready(input logic f, input logic ordy);
    return (m_pending.size() == 0) && (!m_slot_valid || ordy) && !f;
  endfunction

  // Clock the model one cycle with the given inputs.
  function automatic void model_clock(input logic f, input logic v,
                                      input logic [31:0] ins, input logic ordy);
    logic free, acc;
    int   opcd, rt, ra, off;
    logic [15:0] d;
    logic [31:0] w;
    uop_t u;
    free = !m_slot_valid || ordy;
    acc = v && model_in_ready(f, ordy);
    m_illegal = 1'b0;
    opcd = int'(ins[31:26]);
    rt = int'(ins[25:21]);
    ra = int'(ins[20:16]);
    d = ins[15:0];
    if (f) begin
      m_slot_valid = 1'b0;
      m_pending.delete();
    end else if (free) begin
      if (m_pending.size() > 0) begin
        m_slot = m_pending.pop_front();
        m_slot_valid = 1'b1;
      end else if (acc) begin
        if (opcd == 46 && ra != 0 && rt <= ra) begin
          m_illegal = 1'b1;
          m_slot_valid = 1'b0;
        end else if (opcd == 46 || opcd == 47) begin
          for (int k = 0; k <= 31 - rt; k++) begin
            off = int'($signed(d)) + 4 * k;
            w = off;
            u.instr = {(opcd == 46) ? 6'd32 : 6'd36, 5'(rt + k), 5'(ra), w[15:0]};
            u.last = (rt + k == 31);
            u.ovf = (off > 32767) || (off < -32768);
            m_pending.push_back(u);
          end
          m_slot = m_pending.pop_front();
          m_slot_valid = 1'b1;
        end else begin
          m_slot.instr = ins;
          m_slot.last = 1'b1;
          m_slot.ovf = 1'b0;
          m_slot_valid = 1'b1;
        end
      end else begin
        m_slot_valid = 1'b0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check before posedge, advance model and DUT.
  task automatic step(input logic f, input logic v, input logic [31:0] ins, input logic ordy);
    flush = f; in_valid = v; in_instr = ins; out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(model_in_ready(f, ordy)));
    check("out_valid", 32'(out_valid), 32'(m_slot_valid));
    check("illegal", 32'(illegal), 32'(m_illegal));
    if (m_slot_valid) begin
      check("out_instr", out_instr, m_slot.instr);
      check("out_last", 32'(out_last), 32'(m_slot.last));
      check("out_ofs_ovf", 32'(out_ofs_ovf), 32'(m_slot.ovf));
    end
    if (out_valid && ordy && !f) begin
      fired_dut++;
      if (out_ofs_ovf) ovf_dut++;
    end
    model_clock(f, v, ins, ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input bit toggle_ready);
    for (int i = 0; i < 400 && (m_slot_valid || m_pending.size() > 0); i++) begin
      step(1'b0, 1'b0, 32'h0, toggle_ready ? 1'(i % 2 == 0) : 1'b1);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        f, v;
    logic [31:0] ins;
    logic        ordy;
    logic        e_rdy, e_val;
    logic [31:0] e_ins;
    logic        e_last, e_ovf, e_ill;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t row(input logic v, input logic [31:0] ins, input logic ordy,
                               input logic e_rdy, input logic e_val, input logic [31:0] e_ins,
                               input logic e_last, input logic e_ill);
    vec_t r;
    r.f = 1'b0; r.v = v; r.ins = ins; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_val = e_val; r.e_ins = e_ins;
    r.e_last = e_last; r.e_ovf = 1'b0; r.e_ill = e_ill;
    return r;
  endfunction

  initial begin
    logic [31:0] ins;
    int          sel;

    tbl[0]  = row(1, 32'h38610005, 1, 1, 0, 32'h0,        0, 0);
    tbl[1]  = row(1, 32'hBBA10008, 1, 1, 1, 32'h38610005, 1, 0);
    tbl[2]  = row(1, 32'h38600001, 1, 0, 1, 32'h83A10008, 0, 0);
    tbl[3]  = row(1, 32'h38600001, 1, 0, 1, 32'h83C1000C, 0, 0);
    tbl[4]  = row(1, 32'h38600001, 1, 1, 1, 32'h83E10010, 1, 0);
    tbl[5]  = row(0, 32'h0,        1, 1, 1, 32'h38600001, 1, 0);
    tbl[6]  = row(1, 32'hBB9E0000, 1, 1, 0, 32'h0,        0, 0);
    tbl[7]  = row(1, 32'h38610005, 1, 1, 0, 32'h0,        0, 1);
    tbl[8]  = row(1, 32'h38600002, 0, 0, 1, 32'h38610005, 1, 0);
    tbl[9]  = row(1, 32'h38600002, 0, 0, 1, 32'h38610005, 1, 0);
    tbl[10] = row(1, 32'h38600002, 1, 1, 1, 32'h38610005, 1, 0);
    tbl[11] = row(0, 32'h0,        1, 1, 1, 32'h38600002, 1, 0);
    tbl[12] = row(0, 32'h0,        1, 1, 0, 32'h0,        0, 0);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out_instr", out_instr, 32'h0);
    check("rst out_last", 32'(out_last), 32'h0);
    check("rst out_ofs_ovf", 32'(out_ofs_ovf), 32'h0);
    check("rst illegal", 32'(illegal), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      flush = tbl[i].f; in_valid = tbl[i].v; in_instr = tbl[i].ins; out_ready = tbl[i].ordy;
      #1;
      check($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_val));
      check($sformatf("tbl%0d illegal", i), 32'(illegal), 32'(tbl[i].e_ill));
      if (tbl[i].e_val) begin
        check($sformatf("tbl%0d out_instr", i), out_instr, tbl[i].e_ins);
        check($sformatf("tbl%0d out_last", i), 32'(out_last), 32'(tbl[i].e_last));
        check($sformatf("tbl%0d out_ofs_ovf", i), 32'(out_ofs_ovf), 32'(tbl[i].e_ovf));
      end
      @(posedge clk);
      @(negedge clk);
    end
    model_reset();

    // stmw r0,-4(r3) with out_ready toggling: 32 ops, no drops or duplicates
    fired_dut = 0;
    step(1'b0, 1'b1, 32'hBC03FFFC, 1'b1);
    drain(1'b1);
    check("stmw r0 op count", 32'(fired_dut), 32'd32);

    // lmw r24,0x7FF0(r1): 8 ops, last 4 wrap
    fired_dut = 0; ovf_dut = 0;
    step(1'b0, 1'b1, 32'hBB017FF0, 1'b1);
    drain(1'b0);
    check("lmw r24 op count", 32'(fired_dut), 32'd8);
    check("lmw r24 ovf count", 32'(ovf_dut), 32'd4);

    // flush mid-stmw
    step(1'b0, 1'b1, 32'hBC03FFFC, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h38600003, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // reset mid-stmw
    step(1'b0, 1'b1, 32'hBC03FFFC, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 5));
      ins = $urandom;
      if (sel == 0 || sel == 1) begin
        ins[31:26] = (sel == 0) ? 6'd46 : 6'd47;
        if ($urandom_range(0, 2) == 0) ins[20:16] = 5'd0;
        if ($urandom_range(0, 1) == 0) ins[25:21] = 5'(24 + $urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) ins[15:0] = 16'h7FE0 + 16'($urandom_range(0, 31));
      end else if (ins[31:26] == 6'd46 || ins[31:26] == 6'd47) begin
        ins[31:26] = 6'd14;
      end
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 2) != 0), ins,
           1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
